// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed driver for a 4-digit common-anode
// seven-segment display. Scans four BCD-ish digit values, with optional
// leading-zero blanking, per-digit decimal points and whole-display blink.
// All outputs are registered; every state element resets synchronously.
module seven_seg_scan #(
   parameter int REFRESH_DIV = 50000,  // clock cycles per digit slot (>= 2)
   parameter int BLINK_DIV   = 128     // refresh ticks per blink half-period (>= 1)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] digit0,
   input  logic [3:0] digit1,
   input  logic [3:0] digit2,
   input  logic [3:0] digit3,
   input  logic       blank_lz,
   input  logic       blink_en,
   input  logic [3:0] dp_mask,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [RW-1:0] RCNT_MAX = RW'(REFRESH_DIV - 1);
   localparam logic [BW-1:0] BCNT_MAX = BW'(BLINK_DIV - 1);

   localparam logic [6:0] SEG_OFF  = 7'b1111111;
   localparam logic [6:0] SEG_DASH = 7'b0111111;

   // Counter and scan state
   logic [RW-1:0] rcnt_q, rcnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic          bphase_q, bphase_d;

   // Registered display outputs
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;

   // Combinational helpers
   logic          tick;
   logic [3:0]    v;
   logic [6:0]    seg_dec;
   logic          lz_blank;
   logic          blink_off;

   assign tick = (rcnt_q == RCNT_MAX);

   // Next-state for refresh counter, scan index and blink phase
   always_comb begin
      // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
      rcnt_d   = rcnt_q + RW'(1);
      idx_d    = idx_q;
      bcnt_d   = bcnt_q;
      bphase_d = bphase_q;

      if (tick) begin
         rcnt_d = '0;
         idx_d  = idx_q + 2'd1;
      end

      if (!blink_en) begin
         // Holding the blink state cleared guarantees a visible display at blink start.
         bcnt_d   = '0;
         bphase_d = 1'b0;
      end else if (tick) begin
         if (bcnt_q == BCNT_MAX) begin
            bcnt_d   = '0;
            bphase_d = ~bphase_q;
         end else begin
            bcnt_d = bcnt_q + BW'(1);
         end
      end
   end

   // Select the digit for the current slot, decide blanking and decode it
   always_comb begin
      v        = digit0;
      lz_blank = 1'b0;
      unique case (idx_q)
         2'd0: begin
            v        = digit0;
            lz_blank = 1'b0;  // the units digit always shows, so 0000 reads "0"
         end
         2'd1: begin
            v        = digit1;
            lz_blank = (digit1 == 4'd0) && (digit2 == 4'd0) && (digit3 == 4'd0);
         end
         2'd2: begin
            v        = digit2;
            lz_blank = (digit2 == 4'd0) && (digit3 == 4'd0);
         end
         2'd3: begin
            v        = digit3;
            lz_blank = (digit3 == 4'd0);
         end
         default: begin
            v        = digit0;
            lz_blank = 1'b0;
         end
      endcase

      unique case (v)
         4'd0:    seg_dec = 7'b1000000;
         4'd1:    seg_dec = 7'b1111001;
         4'd2:    seg_dec = 7'b0100100;
         4'd3:    seg_dec = 7'b0110000;
         4'd4:    seg_dec = 7'b0011001;
         4'd5:    seg_dec = 7'b0010010;
         4'd6:    seg_dec = 7'b0000010;
         4'd7:    seg_dec = 7'b1111000;
         4'd8:    seg_dec = 7'b0000000;
         4'd9:    seg_dec = 7'b0010000;
         default: seg_dec = SEG_DASH;  // 10..15 are not decimal: show a dash
      endcase
   end

   assign blink_off = blink_en && bphase_q;

   // Output register inputs: normal scan, or all-dark during the blink off-phase
   always_comb begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = (blank_lz && lz_blank) ? SEG_OFF : seg_dec;
      dp_d  = ~dp_mask[idx_q];

      if (blink_off) begin
         an_d  = 4'b1111;
         seg_d = SEG_OFF;
         dp_d  = 1'b1;
      end
   end

   // State and output registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (reset) begin
         rcnt_q   <= '0;
         idx_q    <= 2'd0;
         bcnt_q   <= '0;
         bphase_q <= 1'b0;
         an_q     <= 4'b1111;
         seg_q    <= SEG_OFF;
         dp_q     <= 1'b1;
      end else begin
         rcnt_q   <= rcnt_d;
         idx_q    <= idx_d;
         bcnt_q   <= bcnt_d;
         bphase_q <= bphase_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
         dp_q     <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: self-checking bench for seven_seg_scan with a small
// slot period. A time-based reference model predicts an/seg/dp every cycle;
// directed sequences pin the model with hand-derived literal values, then a
// randomized run exercises digits, blanking, decimal points, blink and reset.
module tb_seven_seg_scan;

   localparam int R = 4;  // REFRESH_DIV
   localparam int B = 2;  // BLINK_DIV

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] digit0, digit1, digit2, digit3;
   logic       blank_lz, blink_en;
   logic [3:0] dp_mask;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   int n_cmp = 0;
   int n_bad = 0;

   seven_seg_scan #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
      .clk      (clk),
      .reset    (reset),
      .digit0   (digit0),
      .digit1   (digit1),
      .digit2   (digit2),
      .digit3   (digit3),
      .blank_lz (blank_lz),
      .blink_en (blink_en),
      .dp_mask  (dp_mask),
      .an       (an),
      .seg      (seg),
      .dp       (dp)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] seg_of(input logic [3:0] val);
      case (val)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   // Reference model: position in the scan comes from the number of edges since
   // reset; blink phase from the number of ticks seen since blink_en went high.
   int         m_t;      // edges since reset released
   int         m_nb;     // ticks counted while blink_en has stayed high
   logic       m_valid = 1'b0;
   logic [3:0] m_an;
   logic [6:0] m_seg;
   logic       m_dp;

   always @(posedge clk) begin
      logic [3:0] dg [4];
      int         k;
      logic       is_tick, off, zeros;
      dg = '{digit0, digit1, digit2, digit3};
      if (reset) begin
         m_an  = 4'b1111;
         m_seg = 7'b1111111;
         m_dp  = 1'b1;
         m_t   = 0;
         m_nb  = 0;
      end else begin
         k       = (m_t / R) % 4;
         is_tick = ((m_t % R) == R - 1);
         off     = blink_en && (((m_nb / B) % 2) == 1);
         zeros   = 1'b1;
         for (int j = k; j < 4; j++) if (dg[j] != 4'd0) zeros = 1'b0;
         if (off) begin
            m_an  = 4'b1111;
            m_seg = 7'b1111111;
            m_dp  = 1'b1;
         end else begin
            m_an  = 4'b1111;
            m_an[k] = 1'b0;
            m_seg = (blank_lz && k != 0 && zeros) ? 7'b1111111 : seg_of(dg[k]);
            m_dp  = ~dp_mask[k];
         end
         m_t++;
         if (!blink_en) m_nb = 0;
         else if (is_tick) m_nb++;
      end
      m_valid = 1'b1;
   end

   // Compare process: every cycle, away from the active edge
   always @(negedge clk) begin
      if (m_valid) begin
         check("model_an", an, m_an);
         check("model_seg", seg, m_seg);
         check("model_dp", dp, m_dp);
      end
   end

   // Step negedges until the given anode pattern shows, bounded
   task automatic wait_an(input logic [3:0] target);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (an !== target && n < 40);
      check("wait_an", an, target);
   endtask

   initial begin
      logic [3:0] prev;
      int         n;

      // Reset with arbitrary inputs
      reset    = 1'b1;
      digit0   = 4'($urandom);
      digit1   = 4'($urandom);
      digit2   = 4'($urandom);
      digit3   = 4'($urandom);
      blank_lz = 1'($urandom);
      blink_en = 1'b0;
      dp_mask  = 4'($urandom);
      repeat (3) @(negedge clk);
      check("rst_an", an, 4'b1111);
      check("rst_seg", seg, 7'b1111111);
      check("rst_dp", dp, 1'b1);

      // Release: four cycles per slot, walking 1110, 1101, 1011, 0111, 1110
      reset = 1'b0;
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         check("scan_an", an, (i < 16) ? 4'(~(4'b0001 << (i / 4))) : 4'b1110);
      end

      // Decode sweep on slot 0
      blank_lz = 1'b0;
      for (int v = 0; v < 16; v++) begin
         digit0 = 4'(v);
         wait_an(4'b1110);
         check("decode", seg, seg_of(4'(v)));
      end
      digit0 = 4'd8; wait_an(4'b1110); check("dec_8", seg, 7'b0000000);
      digit0 = 4'd4; wait_an(4'b1110); check("dec_4", seg, 7'b0011001);
      digit0 = 4'd12; wait_an(4'b1110); check("dec_12", seg, 7'b0111111);

      // Leading-zero blanking: digits 3..0 = 0,0,4,0
      blank_lz = 1'b1;
      digit3 = 4'd0; digit2 = 4'd0; digit1 = 4'd4; digit0 = 4'd0;
      wait_an(4'b0111); check("lz_d3", seg, 7'b1111111);
      wait_an(4'b1011); check("lz_d2", seg, 7'b1111111);
      wait_an(4'b1101); check("lz_d1", seg, 7'b0011001);
      wait_an(4'b1110); check("lz_d0", seg, 7'b1000000);
      digit1 = 4'd0;
      wait_an(4'b1101); check("lz0_d1", seg, 7'b1111111);
      wait_an(4'b1011); check("lz0_d2", seg, 7'b1111111);
      wait_an(4'b0111); check("lz0_d3", seg, 7'b1111111);
      wait_an(4'b1110); check("lz0_d0", seg, 7'b1000000);
      blank_lz = 1'b0;
      digit1 = 4'd4;
      wait_an(4'b0111); check("nolz_d3", seg, 7'b1000000);
      wait_an(4'b1011); check("nolz_d2", seg, 7'b1000000);
      wait_an(4'b1101); check("nolz_d1", seg, 7'b0011001);

      // Decimal point on digit 2 only
      dp_mask = 4'b0100;
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check("dp_pos", dp, (an == 4'b1011) ? 1'b0 : 1'b1);
      end

      // Blink: align so the first sampled cycle is the start of a slot
      digit3 = 4'd1; digit2 = 4'd2; digit1 = 4'd3; digit0 = 4'd4;
      prev = an;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (an === prev && n < 10);
      check("align_slot", (an !== prev), 1'b1);
      repeat (3) @(negedge clk);
      blink_en = 1'b1;
      for (int i = 0; i < 8; i++) begin @(negedge clk); check("blink_vis1", (an != 4'b1111), 1'b1); end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("blink_off_an", an, 4'b1111);
         check("blink_off_seg", seg, 7'b1111111);
      end
      for (int i = 0; i < 8; i++) begin @(negedge clk); check("blink_vis2", (an != 4'b1111), 1'b1); end
      for (int i = 0; i < 3; i++) begin @(negedge clk); check("blink_off2", an, 4'b1111); end
      blink_en = 1'b0;
      @(negedge clk);
      check("blink_drop", (an != 4'b1111), 1'b1);
      blink_en = 1'b1;
      for (int i = 0; i < 4; i++) begin @(negedge clk); check("blink_rearm", (an != 4'b1111), 1'b1); end

      // Mid-operation reset during the blink off-phase
      wait_an(4'b1111);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_an", an, 4'b1111);
      check("midrst_seg", seg, 7'b1111111);
      check("midrst_dp", dp, 1'b1);
      reset = 1'b0;
      @(negedge clk);
      check("midrst_rel_an", an, 4'b1110);
      check("midrst_rel_seg", seg, 7'b0011001);

      // Randomized run checked by the model every cycle
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         reset  = ($urandom_range(0, 299) == 0);
         digit0 = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
         digit1 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
         digit2 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
         digit3 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
         if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
         if ($urandom_range(0, 49) == 0) dp_mask = 4'($urandom);
         if ($urandom_range(0, 99) == 0) blink_en = ~blink_en;
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Time-multiplexed seven-segment display driver for the countdown timer. It consumes the `count_out` values of four chained digit-timer stages and scans them onto a 4-digit common-anode display. It also provides optional leading-zero blanking, per-digit decimal points, and a blink mode used to flash the display when the timer is done. All outputs are registered and change only on clock edges.

## Interface
Parameters:
- `REFRESH_DIV`, default 50000: clock cycles per digit slot; legal range ≥ 2.
- `BLINK_DIV`, default 128: refresh ticks per blink half-period; legal range ≥ 1.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `digit0`  in  4  least-significant digit value (seconds units).
- `digit1`  in  4  digit value.
- `digit2`  in  4  digit value.
- `digit3`  in  4  most-significant digit value.
- `blank_lz`  in  1  1 = blank leading zeros.
- `blink_en`  in  1  1 = flash the whole display.
- `dp_mask`  in  4  bit k = 1 lights the decimal point of digit k.
- `an`  out  4  anode enables, active-low, one-hot-low while scanning.
- `seg`  out  7  segments `{g,f,e,d,c,b,a}`, active-low.
- `dp`  out  1  decimal point, active-low.

## Operation
- **Refresh counter** `rcnt`:
  - Counts 0..`REFRESH_DIV`-1 and wraps.
  - A *tick* is the cycle in which `rcnt` == `REFRESH_DIV`-1.
- **Scan index** `idx` (2 bits):
  - Advances 0→1→2→3→0 on each tick.
- **Blink counter** `bcnt`:
  - Counts ticks 0..`BLINK_DIV`-1 while `blink_en`=1.
  - On a tick with `bcnt`==`BLINK_DIV`-1, `bcnt` wraps to 0 and `bphase` toggles.
  - While `blink_en`=0: `bcnt`=0 and `bphase`=0. The display is therefore always visible at blink start.
- **Selected value** `v` = digit[`idx`].
- **Decode** (active-low `seg`):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10..15 = 0111111 (dash, segment g only).
- **Leading-zero blank**:
  - Digit k (k=1..3) is blanked (`seg`=1111111) when `blank_lz`=1 and digit k through digit 3 are all 0.
  - Digit 0 is never blanked, so a count of 0000 shows "0".
  - `an` still enables a blanked digit's position; `dp` follows `dp_mask`.
- **Blink off-phase** (`blink_en`=1 and `bphase`=1):
  - `an`=1111, `seg`=1111111, `dp`=1.
  - `idx` continues to advance during the off-phase.
- **Normal output**:
  - `an` = 1 everywhere except 0 at bit `idx`.
  - `seg` = decode or blank, as above.
  - `dp` = ~`dp_mask`[`idx`].
- **Reset values**:
  - `rcnt`=0, `idx`=0, `bcnt`=0, `bphase`=0.
  - `an`=1111, `seg`=1111111, `dp`=1.
- **Reset mid-scan or mid-blink**:
  - Takes effect on the next edge.
  - All state returns to the reset values with no residual phase.

## Timing
- **Output register stage**:
  - `an`/`seg`/`dp` are registered from `idx`, `bphase` and the inputs as sampled at the same edge that updates them.
  - Input change to output change: 1 clock.
- **First edge after reset deasserts**:
  - `an`=1110, showing `digit0`.
  - `rcnt` counts 0..`REFRESH_DIV`-1 from that point.
- **Digit slots**:
  - Each slot lasts exactly `REFRESH_DIV` cycles.
  - A full frame lasts 4·`REFRESH_DIV` cycles.
  - `an` transitions directly from one one-hot-low value to the next, with no all-off gap.
- **Blink half-period**: `BLINK_DIV`·`REFRESH_DIV` cycles.
- **Blink edges**:
  - `blink_en` 0→1: first blank output appears after `BLINK_DIV` ticks.
  - `blink_en` 1→0: display visible on the next edge.
- **Digit inputs**:
  - Not synchronised; they must come from the same `clk` domain.
  - A digit change during its own slot appears on the next edge.

## Test plan
Use `REFRESH_DIV`=4, `BLINK_DIV`=2.
- **Reset**: assert `reset` with arbitrary inputs → `an`=1111, `seg`=1111111, `dp`=1. Release → `an`=1110 for 4 cycles, then 1101, 1011, 0111, 1110.
- **Decode sweep**: set `digit0` to 0..15 while slot 0 is active → `seg` matches the table; 10..15 → 0111111.
- **Leading-zero blanking**: digits 3..0 = 0,0,4,0 with `blank_lz`=1:
  - Slots 3 and 2 → `seg`=1111111.
  - Slot 1 → 0011001.
  - Slot 0 → 1000000.
  - All zeros → only slot 0 shows 1000000.
  - With `blank_lz`=0 → every slot shows its digit.
- **Decimal point**: `dp_mask`=0100 → `dp`=0 only while `an`=1011.
- **Blink**: `blink_en`=1 →
  - Visible for 8 cycles, then `an`=1111 for 8 cycles, repeating.
  - Drop `blink_en` during the off-phase → visible on the next edge.
  - Re-raise `blink_en` → a full visible half-period before the next off-phase.
- **Mid-operation reset**: assert `reset` for 1 cycle during slot 2 with blink in the off-phase → all state returns to reset values, and `an`=1110 on the first edge after release.
